// File: rtl/apb_pkg.sv
// Shared APB constants and the initiator FSM state type for the audioport register space.
package apb_pkg;

  localparam logic [31:0] APB_START_ADDRESS   = 32'h8c00_0000;
  localparam logic [31:0] APB_END_ADDRESS     = 32'h8c00_07ff;
  localparam int unsigned APB_MAX_WAIT_STATES = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_init_state_t;

endpackage

// File: rtl/apb_initiator.sv
// APB3 requester: turns valid/ready single-word requests into APB transfers, rejecting
// out-of-window or misaligned addresses locally and bounding PREADY wait states.
module apb_initiator
  import apb_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS   = APB_START_ADDRESS,
  parameter logic [31:0] END_ADDRESS     = APB_END_ADDRESS,
  parameter int unsigned MAX_WAIT_STATES = APB_MAX_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned WcntW =
    (MAX_WAIT_STATES > 0) ? $clog2(MAX_WAIT_STATES + 1) : 1;
  localparam logic [WcntW-1:0] WcntMax = WcntW'(MAX_WAIT_STATES);

  apb_init_state_t state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             pwrite_q, pwrite_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             addr_ok;

  assign addr_ok = (req_addr >= START_ADDRESS) && (req_addr <= END_ADDRESS) &&
                   (req_addr[1:0] == 2'b00);

  // PSEL/PENABLE are computed from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_ok) begin
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pwrite_d = req_write;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        wcnt_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
          state_d     = IDLE;
        end else if (wcnt_q != WcntMax) begin
          // Counter stops at WcntMax, so it saturates rather than wraps.
          wcnt_d    = wcnt_q + WcntW'(1);
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: u_dut allows two wait states, u_dut0 uses the default of zero.
module tb_apb_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1;
  logic        PSLVERR = 1'b0;

  logic        req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic        d0_req_ready, d0_rsp_valid, d0_rsp_err, d0_psel, d0_penable, d0_pwrite;
  logic [31:0] d0_rsp_rdata, d0_paddr, d0_pwdata;

  // {req_ready, PSEL, PENABLE, rsp_valid, rsp_err}
  logic [4:0] ctl, ctl0;
  assign ctl  = {req_ready, PSEL, PENABLE, rsp_valid, rsp_err};
  assign ctl0 = {d0_req_ready, d0_psel, d0_penable, d0_rsp_valid, d0_rsp_err};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_initiator #(.MAX_WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_initiator u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(d0_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d0_rsp_valid), .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err),
    .PSEL(d0_psel), .PENABLE(d0_penable), .PWRITE(d0_pwrite), .PADDR(d0_paddr),
    .PWDATA(d0_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Presents a request for one cycle (cycle N); returns at the negedge of cycle N+1.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (ctl !== 5'b10000) begin
      miscompares++; $display("FAIL reset_ctl got %b exp %b", ctl, 5'b10000);
    end
    vectors++;
    if ({PWRITE, PADDR, PWDATA, rsp_rdata} !== 97'h0) begin
      miscompares++;
      $display("FAIL reset_bus got %h exp 0", {PWRITE, PADDR, PWDATA, rsp_rdata});
    end
    vectors++;
    if (ctl0 !== 5'b10000) begin
      miscompares++; $display("FAIL reset_ctl0 got %b exp %b", ctl0, 5'b10000);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hdead_beef;
    issue(1'b0, 32'h8c00_0010, 32'h0);
    vectors++;
    if (ctl !== 5'b01000) begin
      miscompares++; $display("FAIL rd_setup_ctl got %b exp %b", ctl, 5'b01000);
    end
    vectors++;
    if ({PWRITE, PADDR} !== {1'b0, 32'h8c00_0010}) begin
      miscompares++; $display("FAIL rd_setup_addr got %h exp %h", {PWRITE, PADDR},
                              {1'b0, 32'h8c00_0010});
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b01100) begin
      miscompares++; $display("FAIL rd_access_ctl got %b exp %b", ctl, 5'b01100);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b10010) begin
      miscompares++; $display("FAIL rd_rsp_ctl got %b exp %b", ctl, 5'b10010);
    end
    vectors++;
    if (rsp_rdata !== 32'hdead_beef) begin
      miscompares++; $display("FAIL rd_rsp_data got %h exp %h", rsp_rdata, 32'hdead_beef);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b10000) begin
      miscompares++; $display("FAIL rd_after_ctl got %b exp %b", ctl, 5'b10000);
    end
  endtask

  task automatic test_write_slverr();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hdead_beef;
    issue(1'b1, 32'h8c00_0004, 32'h0000_00a5);
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (ctl !== (c == 0 ? 5'b01000 : 5'b01100)) begin
        miscompares++; $display("FAIL wr_phase%0d_ctl got %b exp %b", c, ctl,
                                (c == 0 ? 5'b01000 : 5'b01100));
      end
      vectors++;
      if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h8c00_0004, 32'h0000_00a5}) begin
        miscompares++; $display("FAIL wr_phase%0d_bus got %h exp %h", c,
                                {PWRITE, PADDR, PWDATA}, {1'b1, 32'h8c00_0004, 32'h0000_00a5});
      end
      @(negedge clk);
    end
    vectors++;
    if (ctl !== 5'b10011) begin
      miscompares++; $display("FAIL wr_rsp_ctl got %b exp %b", ctl, 5'b10011);
    end
    vectors++;
    if (rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL wr_rsp_data got %h exp 0", rsp_rdata);
    end
    PSLVERR = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h1234_5678;
    issue(1'b0, 32'h8c00_0020, 32'h0);
    vectors++;
    if ({ctl, ctl0} !== {5'b01000, 5'b01000}) begin
      miscompares++; $display("FAIL to_setup got %b/%b exp 01000/01000", ctl, ctl0);
    end
    @(negedge clk);
    vectors++;
    if ({ctl, ctl0} !== {5'b01100, 5'b01100}) begin
      miscompares++; $display("FAIL to_access1 got %b/%b exp 01100/01100", ctl, ctl0);
    end
    @(negedge clk);
    vectors++;
    if ({ctl, ctl0} !== {5'b01100, 5'b10011}) begin
      miscompares++; $display("FAIL to_access2 got %b/%b exp 01100/10011", ctl, ctl0);
    end
    vectors++;
    if (d0_rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL to_dut0_data got %h exp 0", d0_rsp_rdata);
    end
    @(negedge clk);
    vectors++;
    if ({ctl, ctl0} !== {5'b01100, 5'b10000}) begin
      miscompares++; $display("FAIL to_access3 got %b/%b exp 01100/10000", ctl, ctl0);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b10011) begin
      miscompares++; $display("FAIL to_rsp_ctl got %b exp %b", ctl, 5'b10011);
    end
    vectors++;
    if (rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL to_rsp_data got %h exp 0", rsp_rdata);
    end
    PREADY = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reject();
    logic [31:0] bad [3];
    bad[0] = 32'h8c00_0800; bad[1] = 32'h8c00_0002; bad[2] = 32'h8bff_fffc;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = bad[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b10011) begin
        miscompares++; $display("FAIL rej%0d_ctl got %b exp %b", i, ctl, 5'b10011);
      end
      vectors++;
      if (rsp_rdata !== 32'h0) begin
        miscompares++; $display("FAIL rej%0d_data got %h exp 0", i, rsp_rdata);
      end
      if (i < 2) req_addr = bad[i+1];
      else req_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b10000) begin
      miscompares++; $display("FAIL rej_after_ctl got %b exp %b", ctl, 5'b10000);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] ok [2];
    ok[0] = 32'h8c00_07fc; ok[1] = 32'h8c00_0000;
    PREADY = 1'b1; PRDATA = 32'h0bad_f00d;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, ok[i], 32'h0);
      vectors++;
      if ({ctl, PADDR} !== {5'b01000, ok[i]}) begin
        miscompares++; $display("FAIL edge%0d_setup got %b %h exp 01000 %h", i, ctl, PADDR, ok[i]);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if ({ctl, rsp_rdata} !== {5'b10010, 32'h0bad_f00d}) begin
        miscompares++;
        $display("FAIL edge%0d_rsp got %b %h exp 10010 0badf00d", i, ctl, rsp_rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    PREADY = 1'b1; PRDATA = 32'h5555_aaaa;
    issue(1'b0, 32'h8c00_0030, 32'h0);
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b01100) begin
      miscompares++; $display("FAIL rstmid_access got %b exp %b", ctl, 5'b01100);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ctl !== 5'b10000) begin
      miscompares++; $display("FAIL rstmid_async got %b exp %b", ctl, 5'b10000);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b10000) begin
        miscompares++; $display("FAIL rstmid_quiet%0d got %b exp %b", c, ctl, 5'b10000);
      end
    end
    PRDATA = 32'h1234_5678;
    issue(1'b0, 32'h8c00_0040, 32'h0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({ctl, rsp_rdata} !== {5'b10010, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL rstmid_next got %b %h exp 10010 12345678", ctl, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PSLVERR = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8c00_0100; PRDATA = 32'ha000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (ctl !== 5'b01000) begin
        miscompares++; $display("FAIL b2b%0d_setup got %b exp %b", i, ctl, 5'b01000);
      end
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b01100) begin
        miscompares++; $display("FAIL b2b%0d_access got %b exp %b", i, ctl, 5'b01100);
      end
      @(negedge clk);
      vectors++;
      if ({ctl, rsp_rdata} !== {5'b10010, 32'ha000_0000 + 32'(i)}) begin
        miscompares++; $display("FAIL b2b%0d_rsp got %b %h exp 10010 %h", i, ctl, rsp_rdata,
                                32'ha000_0000 + 32'(i));
      end
      if (i < 9) begin
        req_valid = 1'b1;
        req_addr  = 32'h8c00_0100 + 32'(4 * (i + 1));
        PRDATA    = 32'ha000_0000 + 32'(i + 1);
      end
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 5'b10000) begin
      miscompares++; $display("FAIL b2b_after got %b exp %b", ctl, 5'b10000);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_slverr();
    test_timeout();
    test_reject();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
